// File: rtl/logip_pkg.sv
// Shared definitions for the sample readout path.
//   readout_state_t : readout sequencer states
//   SAMPLE_W        : sample word width
//   MEM_RD_LAT      : sample RAM read latency in cycles. The sequencer's
//                     single WAIT state covers exactly this latency.
package logip_pkg;
  localparam int SAMPLE_W   = 32;
  localparam int MEM_RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    DONE
  } readout_state_t;
endpackage

// File: rtl/tx_readout_if.sv
// Bus bundle between the readout sequencer, the sample RAM read port and
// the UART TX word handshake.
//   mem_rd_o / mem_addr_o : RAM read strobe and address (sequencer drives)
//   mem_data_i            : RAM read data, valid one cycle after mem_rd_o
//   stb_o / data_o        : word offered to the UART TX (sequencer drives)
//   rdy_i                 : UART TX accepts the word while stb_o is high
// master = sequencer side, slave = RAM/UART side.
interface tx_readout_if #(parameter int ADDR_W = 10);
  import logip_pkg::*;

  logic                mem_rd_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [SAMPLE_W-1:0] mem_data_i;
  logic                stb_o;
  logic [SAMPLE_W-1:0] data_o;
  logic                rdy_i;

  modport master (
    output mem_rd_o, mem_addr_o, stb_o, data_o,
    input  mem_data_i, rdy_i
  );

  modport slave (
    input  mem_rd_o, mem_addr_o, stb_o, data_o,
    output mem_data_i, rdy_i
  );
endinterface

// File: rtl/tx_readout.sv
// Readout sequencer: on start, fetches cnt_i samples from the sample RAM one
// word at a time and hands each word to the UART TX over stb/rdy.
//   clk_i, rst_in     : clock, async active-low reset
//   start_i, abort_i  : start command (ignored while busy), synchronous cancel
//   last_addr_i,cnt_i : newest sample address and word count, taken at start
//   busy_o, done_o    : readout in progress, one-cycle completion pulse
//   bus (master)      : RAM read port and UART TX word handshake
// Build option LOGIP_READOUT_REVERSE_EN: newest sample first (start at
// last_addr_i, decrement). Default: oldest first (start at
// last_addr_i - count + 1, increment). Addresses wrap modulo 2^ADDR_W.
module tx_readout
  import logip_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  input  logic [ADDR_W:0]   cnt_i,
  output logic              busy_o,
  output logic              done_o,
  tx_readout_if.master      bus
);

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   C_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  readout_state_t      state_q, state_d;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                stb_q;
  logic [SAMPLE_W-1:0] data_q;

  logic [ADDR_W:0]     cnt_eff;
  logic [ADDR_W-1:0]   addr_start, addr_next;
  logic                accept, capture, xfer;

  // A full-depth request is the most the RAM can hold.
  assign cnt_eff = (cnt_i > DEPTH) ? DEPTH : cnt_i;

`ifdef LOGIP_READOUT_REVERSE_EN
  assign addr_start = last_addr_i;
  assign addr_next  = addr_q - A_ONE;
`else
  // For a full-depth count the low bits are 0, giving last+1: the oldest word.
  assign addr_start = last_addr_i - cnt_eff[ADDR_W-1:0] + A_ONE;
  assign addr_next  = addr_q + A_ONE;
`endif

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    capture      = 1'b0;
    xfer         = 1'b0;
    bus.mem_rd_o = (state_q == FETCH);
    busy_o       = (state_q != IDLE);
    done_o       = (state_q == DONE);
    case (state_q)
      IDLE: begin
        // start together with abort is dropped
        if (start_i && !abort_i) begin
          accept  = 1'b1;
          state_d = (cnt_eff == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = abort_i ? IDLE : WAIT;
      WAIT: begin
        if (abort_i) state_d = IDLE;
        else begin
          capture = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // abort wins over a transfer in the same cycle
        if (abort_i) state_d = IDLE;
        else if (stb_q && bus.rdy_i) begin
          xfer    = 1'b1;
          state_d = (cnt_q == C_ONE) ? DONE : FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q  <= '0;
      addr_q <= '0;
      stb_q  <= 1'b0;
      data_q <= '0;
    end else begin
      if (accept) begin
        cnt_q  <= cnt_eff;
        addr_q <= addr_start;
      end
      if (capture) begin
        data_q <= bus.mem_data_i;
        stb_q  <= 1'b1;
      end
      if (xfer) begin
        stb_q  <= 1'b0;
        cnt_q  <= cnt_q - C_ONE;
        addr_q <= addr_next;
      end
      if (abort_i && state_q != IDLE) stb_q <= 1'b0;
    end
  end

  assign bus.mem_addr_o = addr_q;
  assign bus.stb_o      = stb_q;
  assign bus.data_o     = data_q;

endmodule

// File: tb/tb_tx_readout.sv
// Directed bench for tx_readout with ADDR_W=4. A small RAM model answers
// reads one cycle after mem_rd_o and drives a poison value otherwise.
// Expected address orders follow LOGIP_READOUT_REVERSE_EN.
module tb_tx_readout;
  import logip_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [AW:0]   cnt_in = '0;
  logic          busy, done;

  tx_readout_if #(.ADDR_W(AW)) bus ();

  tx_readout #(.ADDR_W(AW)) dut (
    .clk_i       (clk),
    .rst_in      (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .last_addr_i (last_addr),
    .cnt_i       (cnt_in),
    .busy_o      (busy),
    .done_o      (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [16];
  initial for (int i = 0; i < 16; i++) ram[i] = 32'hA5C3_0000 + 32'(i * 32'h0001_0111);

  always @(posedge clk)
    if (bus.mem_rd_o) bus.mem_data_i <= ram[bus.mem_addr_o];
    else              bus.mem_data_i <= 32'hDEAD_BEEF;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] addr_log[$];
  logic [31:0]   data_log[$];
  int n_done, first_rd, first_stb, done_cyc, end_cyc;

  // Issue one start and log reads, transfers and done pulses until busy drops.
  task automatic run_readout(input logic [AW-1:0] la, input logic [AW:0] cn);
    addr_log.delete(); data_log.delete();
    n_done = 0; first_rd = -1; first_stb = -1; done_cyc = -1; end_cyc = -1;
    last_addr = la; cnt_in = cn; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (bus.mem_rd_o) begin
        addr_log.push_back(bus.mem_addr_o);
        if (first_rd < 0) first_rd = c;
      end
      if (bus.stb_o) begin
        if (first_stb < 0) first_stb = c;
        if (bus.rdy_i) data_log.push_back(bus.data_o);
      end
      if (done) begin n_done++; done_cyc = c; end
      if (!busy) begin end_cyc = c; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    bus.rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({bus.mem_rd_o, bus.stb_o, busy, done} !== 4'b0) begin errors++;
      $display("FAIL reset_ctl: got %b want 0000", {bus.mem_rd_o, bus.stb_o, busy, done}); end
    checks++; if (bus.mem_addr_o !== 4'h0) begin errors++;
      $display("FAIL reset_addr: got %h want 0", bus.mem_addr_o); end
    checks++; if (bus.data_o !== 32'h0) begin errors++;
      $display("FAIL reset_data: got %h want 0", bus.data_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.mem_rd_o, bus.stb_o, busy, done} !== 4'b0) begin errors++;
      $display("FAIL idle_after_reset: got %b want 0000", {bus.mem_rd_o, bus.stb_o, busy, done}); end
  endtask

  task automatic test_basic;
`ifdef LOGIP_READOUT_REVERSE_EN
    logic [AW-1:0] ea[3] = '{4'd5, 4'd4, 4'd3};
`else
    logic [AW-1:0] ea[3] = '{4'd3, 4'd4, 4'd5};
`endif
    logic [AW-1:0] ga;
    logic [31:0] gd;
    bus.rdy_i = 1'b1;
    run_readout(4'd5, 5'd3);
    checks++; if (end_cyc < 0) begin errors++; $display("FAIL basic_timeout: busy never fell"); end
    checks++; if (addr_log.size() !== 3) begin errors++;
      $display("FAIL basic_nreads: got %0d want 3", addr_log.size()); end
    for (int i = 0; i < 3; i++) begin
      ga = (i < addr_log.size()) ? addr_log[i] : 'x;
      gd = (i < data_log.size()) ? data_log[i] : 'x;
      checks++; if (ga !== ea[i]) begin errors++;
        $display("FAIL basic_addr[%0d]: got %h want %h", i, ga, ea[i]); end
      checks++; if (gd !== ram[ea[i]]) begin errors++;
        $display("FAIL basic_data[%0d]: got %h want %h", i, gd, ram[ea[i]]); end
    end
    checks++; if (first_rd !== 1) begin errors++; $display("FAIL basic_rd_cycle: got %0d want 1", first_rd); end
    checks++; if (first_stb !== 3) begin errors++; $display("FAIL basic_stb_cycle: got %0d want 3", first_stb); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_ndone: got %0d want 1", n_done); end
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL basic_done_cycle: got %0d want 10", done_cyc); end
    checks++; if (end_cyc !== 11) begin errors++; $display("FAIL basic_busy_fall: got %0d want 11", end_cyc); end
  endtask

  task automatic test_wrap;
`ifdef LOGIP_READOUT_REVERSE_EN
    logic [AW-1:0] ea[4] = '{4'd1, 4'd0, 4'd15, 4'd14};
`else
    logic [AW-1:0] ea[4] = '{4'd14, 4'd15, 4'd0, 4'd1};
`endif
    logic [AW-1:0] ga;
    logic [31:0] gd;
    run_readout(4'd1, 5'd4);
    checks++; if (addr_log.size() !== 4) begin errors++;
      $display("FAIL wrap_nreads: got %0d want 4", addr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      ga = (i < addr_log.size()) ? addr_log[i] : 'x;
      gd = (i < data_log.size()) ? data_log[i] : 'x;
      checks++; if (ga !== ea[i]) begin errors++;
        $display("FAIL wrap_addr[%0d]: got %h want %h", i, ga, ea[i]); end
      checks++; if (gd !== ram[ea[i]]) begin errors++;
        $display("FAIL wrap_data[%0d]: got %h want %h", i, gd, ram[ea[i]]); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL wrap_ndone: got %0d want 1", n_done); end
  endtask

  task automatic test_stall;
    int xfers = 0;
    int bad = 0;
    bit seen = 0;
    bus.rdy_i = 1'b0;
    last_addr = 4'd9; cnt_in = 5'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.stb_o) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_stb_timeout: stb never rose"); end
    for (int c = 0; c < 20; c++) begin
      if (bus.stb_o && bus.rdy_i) xfers++;
      if (bus.stb_o !== 1'b1 || bus.data_o !== ram[9]) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL stall_hold: %0d unstable cycles, stb=%b data=%h want 1/%h", bad, bus.stb_o, bus.data_o, ram[9]); end
    bus.rdy_i = 1'b1;
    if (bus.stb_o && bus.rdy_i) xfers++;
    @(posedge clk); #1;
    if (bus.stb_o && bus.rdy_i) xfers++;
    checks++; if ({bus.stb_o, done} !== 2'b01) begin errors++;
      $display("FAIL stall_release: stb,done got %b want 01", {bus.stb_o, done}); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy: got %b want 0", busy); end
    checks++; if (xfers !== 1) begin errors++; $display("FAIL stall_xfers: got %0d want 1", xfers); end
  endtask

  task automatic test_zero_count;
    run_readout(4'd7, 5'd0);
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL zero_ndone: got %0d want 1", n_done); end
    checks++; if (addr_log.size() !== 0 || first_stb !== -1) begin errors++;
      $display("FAIL zero_activity: reads %0d stb_cycle %0d want 0/-1", addr_log.size(), first_stb); end
    checks++; if (end_cyc !== 2) begin errors++; $display("FAIL zero_busy_fall: got %0d want 2", end_cyc); end
  endtask

  task automatic test_clamp;
    logic [AW-1:0] ea, ga;
    int bad = 0;
    run_readout(4'd7, 5'd20);
    checks++; if (data_log.size() !== 16) begin errors++;
      $display("FAIL clamp_nwords: got %0d want 16", data_log.size()); end
    for (int i = 0; i < 16; i++) begin
`ifdef LOGIP_READOUT_REVERSE_EN
      ea = 4'(7 - i);
`else
      ea = 4'(8 + i);
`endif
      ga = (i < addr_log.size()) ? addr_log[i] : 'x;
      if (ga !== ea) bad++;
      if (i < data_log.size()) begin if (data_log[i] !== ram[ea]) bad++; end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clamp_sequence: %0d wrong words/addresses want 0", bad); end
    checks++; if (done_cyc !== 49) begin errors++; $display("FAIL clamp_done_cycle: got %0d want 49", done_cyc); end
  endtask

  task automatic test_abort;
    int xfers = 0;
    int nd = 0;
    bit hit = 0;
    bus.rdy_i = 1'b1;
    last_addr = 4'd10; cnt_in = 5'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      if (bus.stb_o && xfers == 1) hit = 1;
      else begin
        if (bus.stb_o) xfers++;
        @(posedge clk); #1;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_reach: second word never offered"); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if ({bus.stb_o, busy, done, bus.mem_rd_o} !== 4'b0) begin errors++;
      $display("FAIL abort_exit: stb,busy,done,rd got %b want 0000", {bus.stb_o, busy, done, bus.mem_rd_o}); end
    repeat (5) begin if (done) nd++; @(posedge clk); #1; end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_with_abort: busy got %b want 0", busy); end
    run_readout(4'd2, 5'd2);
    checks++; if (n_done !== 1 || data_log.size() !== 2) begin errors++;
      $display("FAIL abort_restart: done %0d words %0d want 1/2", n_done, data_log.size()); end
  endtask

  task automatic test_async_reset;
    bit seen = 0;
    bus.rdy_i = 1'b0;
    last_addr = 4'd3; cnt_in = 5'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.stb_o) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL areset_stb_timeout: stb never rose"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.mem_rd_o, bus.stb_o, busy, done} !== 4'b0 || bus.data_o !== 32'h0 || bus.mem_addr_o !== 4'h0) begin
      errors++; $display("FAIL areset_outputs: ctl %b addr %h data %h want 0000/0/0",
        {bus.mem_rd_o, bus.stb_o, busy, done}, bus.mem_addr_o, bus.data_o); end
    #1 rst_n = 1'b1;
    bus.rdy_i = 1'b1;
    @(posedge clk); #1;
    run_readout(4'd6, 5'd1);
    checks++; if (n_done !== 1 || data_log.size() !== 1 || (data_log.size() == 1 && data_log[0] !== ram[6])) begin
      errors++; $display("FAIL areset_recover: done %0d words %0d want 1/1 with %h", n_done, data_log.size(), ram[6]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_count();
    test_clamp();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
